// File: rtl/time_program_pkg.sv
// Shared egg-timer definitions: FSM state encoding, edited-digit encoding,
// BCD wrap limits and the digit increment helper.
package time_program_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] DIG_SEC  = 2'd0;
  localparam logic [1:0] DIG_TSEC = 2'd1;
  localparam logic [1:0] DIG_MIN  = 2'd2;
  localparam logic [1:0] DIG_TMIN = 2'd3;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  localparam int unsigned ALARM_CNT_W = 4;

  // Wrap to zero at or above the limit so a digit can never leave BCD range.
  function automatic logic [3:0] bcd_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/time_program_edge_detect.sv
// Rising-edge detector for a synchronous, debounced button level.
// History resets to 0 so a button held through reset release still
// produces an event on the first edge afterwards.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_prev;

  // Remember the level seen on the previous clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_prev <= 1'b0;
    else       in_prev <= in;
  end

  assign rise = in & ~in_prev;

endmodule

// File: rtl/time_program.sv
// Cook-time programming controller for the egg timer.
//
// state | meaning
// IDLE  | waiting; programmed time held, set enters EDIT, start runs
// EDIT  | editing digit digit_sel with inc, set advances the digit
// RUN   | time_count enabled, digits frozen, start cancels
// DONE  | alarm sounding for ALARM_SECS seconds or until any button
module time_program
  import time_program_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_1s,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_start,
  input  logic       timer_done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       timer_on,
  output logic [1:0] digit_sel,
  output logic       edit_mode,
  output logic       alarm
);

  localparam logic [ALARM_CNT_W-1:0] ALARM_LOAD = ALARM_CNT_W'(ALARM_SECS);

  logic set_ev, inc_ev, start_ev;

  state_t state_q, state_d;
  logic [3:0] sec_q, tsec_q, min_q, tmin_q;
  logic [3:0] sec_d, tsec_d, min_d, tmin_d;
  logic [1:0] sel_q, sel_d;
  logic [ALARM_CNT_W-1:0] cnt_q, cnt_d;
  logic any_ev, time_nonzero;

  edge_detect u_set (
    .clk   (clk),
    .reset (reset),
    .in    (btn_set),
    .rise  (set_ev)
  );

  edge_detect u_inc (
    .clk   (clk),
    .reset (reset),
    .in    (btn_inc),
    .rise  (inc_ev)
  );

  edge_detect u_start (
    .clk   (clk),
    .reset (reset),
    .in    (btn_start),
    .rise  (start_ev)
  );

  assign any_ev       = set_ev | inc_ev | start_ev;
  assign time_nonzero = |{sec_q, tsec_q, min_q, tmin_q};

  // Next-state, digit edit and alarm-counter logic; start > set > inc.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    tsec_d  = tsec_q;
    min_d   = min_q;
    tmin_d  = tmin_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          if (time_nonzero) begin
            state_d = ST_RUN;
            sel_d   = DIG_SEC;
          end
        end else if (set_ev) begin
          state_d = ST_EDIT;
          sel_d   = DIG_SEC;
        end
      end

      ST_EDIT: begin
        if (start_ev) begin
          if (time_nonzero) begin
            state_d = ST_RUN;
            sel_d   = DIG_SEC;
          end
        end else if (set_ev) begin
          if (sel_q == DIG_TMIN) begin
            state_d = ST_IDLE;
            sel_d   = DIG_SEC;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else if (inc_ev) begin
          unique case (sel_q)
            DIG_SEC:  sec_d  = bcd_inc(sec_q,  UNITS_MAX);
            DIG_TSEC: tsec_d = bcd_inc(tsec_q, TENS_MAX);
            DIG_MIN:  min_d  = bcd_inc(min_q,  UNITS_MAX);
            DIG_TMIN: tmin_d = bcd_inc(tmin_q, UNITS_MAX);
            default:  ;
          endcase
        end
      end

      ST_RUN: begin
        // Expiry wins over a same-cycle cancel so the alarm is never lost.
        if (timer_done) begin
          state_d = ST_DONE;
          cnt_d   = ALARM_LOAD;
        end else if (start_ev) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (any_ev) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (pulse_1s) begin
          if (cnt_q <= ALARM_CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ALARM_CNT_W'(1);
          end
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, programmed digits and alarm counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      tsec_q  <= '0;
      min_q   <= '0;
      tmin_q  <= '0;
      sel_q   <= DIG_SEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      tsec_q  <= tsec_d;
      min_q   <= min_d;
      tmin_q  <= tmin_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs come straight from flops, decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_on  <= 1'b0;
      edit_mode <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      timer_on  <= (state_d == ST_RUN);
      edit_mode <= (state_d == ST_EDIT);
      alarm     <= (state_d == ST_DONE);
    end
  end

  assign seconds_prog      = sec_q;
  assign tens_seconds_prog = tsec_q;
  assign minutes_prog      = min_q;
  assign tens_minutes_prog = tmin_q;
  assign digit_sel         = sel_q;

endmodule

// File: tb/tb_time_program.sv
// Directed bench for time_program: a table of button/timer events with
// hand-computed outputs, then hand sequences for reset and held buttons.
module tb_time_program;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_1s, btn_set, btn_inc, btn_start, timer_done;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       timer_on, edit_mode, alarm;
  logic [1:0] digit_sel;

  int total = 0;
  int bad   = 0;

  time_program #(.ALARM_SECS(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .pulse_1s          (pulse_1s),
    .btn_set           (btn_set),
    .btn_inc           (btn_inc),
    .btn_start         (btn_start),
    .timer_done        (timer_done),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .timer_on          (timer_on),
    .digit_sel         (digit_sel),
    .edit_mode         (edit_mode),
    .alarm             (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        set, inc, start, done, pulse;
    int          reps;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {sec, tsec, min, tmin, sel, edit, on, alarm}
  function automatic logic [20:0] mk(int s, int ts, int m, int tm, int sel,
                                     int ed, int on, int al);
    return {4'(s), 4'(ts), 4'(m), 4'(tm), 2'(sel), 1'(ed), 1'(on), 1'(al)};
  endfunction

  function automatic void add(string n, logic s, logic i, logic st, logic d,
                              logic p, int reps, logic [20:0] e);
    vec_t v;
    v.name = n; v.set = s; v.inc = i; v.start = st; v.done = d; v.pulse = p;
    v.reps = reps; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [20:0] e);
    logic [20:0] got;
    got = {seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
           digit_sel, edit_mode, timer_on, alarm};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got s=%0d ts=%0d m=%0d tm=%0d sel=%0d ed=%0b on=%0b al=%0b, want s=%0d ts=%0d m=%0d tm=%0d sel=%0d ed=%0b on=%0b al=%0b",
               n, got[20:17], got[16:13], got[12:9], got[8:5], got[4:3], got[2], got[1], got[0],
               e[20:17], e[16:13], e[12:9], e[8:5], e[4:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic drive(input logic s, input logic i, input logic st,
                       input logic d, input logic p);
    btn_set = s; btn_inc = i; btn_start = st; timer_done = d; pulse_1s = p;
  endtask

  // One press cycle then one release cycle; called at a negedge.
  task automatic press(input logic s, input logic i, input logic st,
                       input logic d, input logic p);
    drive(s, i, st, d, p);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;

    add("reset_state",   0,0,0,0,0, 1, mk(0,0,0,0,0,0,0,0));
    add("idle_start_0",  0,0,1,0,0, 1, mk(0,0,0,0,0,0,0,0));
    add("idle_inc_ign",  0,1,0,0,0, 1, mk(0,0,0,0,0,0,0,0));
    add("set_to_edit",   1,0,0,0,0, 1, mk(0,0,0,0,0,1,0,0));
    add("inc_sec_x4",    0,1,0,0,0, 4, mk(4,0,0,0,0,1,0,0));
    add("set_sel1",      1,0,0,0,0, 1, mk(4,0,0,0,1,1,0,0));
    add("inc_tsec_x3",   0,1,0,0,0, 3, mk(4,3,0,0,1,1,0,0));
    add("set_sel2",      1,0,0,0,0, 1, mk(4,3,0,0,2,1,0,0));
    add("inc_min_x2",    0,1,0,0,0, 2, mk(4,3,2,0,2,1,0,0));
    add("set_sel3",      1,0,0,0,0, 1, mk(4,3,2,0,3,1,0,0));
    add("prog_4321",     0,1,0,0,0, 1, mk(4,3,2,1,3,1,0,0));
    add("set_sel3_idle", 1,0,0,0,0, 1, mk(4,3,2,1,0,0,0,0));
    add("reenter_edit",  1,0,0,0,0, 1, mk(4,3,2,1,0,1,0,0));
    add("sel1_again",    1,0,0,0,0, 1, mk(4,3,2,1,1,1,0,0));
    add("tsec_wrap_5_0", 0,1,0,0,0, 3, mk(4,0,2,1,1,1,0,0));
    add("tsec_inc_x6",   0,1,0,0,0, 6, mk(4,0,2,1,1,1,0,0));
    add("set_x3_idle",   1,0,0,0,0, 3, mk(4,0,2,1,0,0,0,0));
    add("edit_sel0",     1,0,0,0,0, 1, mk(4,0,2,1,0,1,0,0));
    add("sec_wrap_9_0",  0,1,0,0,0, 6, mk(0,0,2,1,0,1,0,0));
    add("sec_inc_x10",   0,1,0,0,0, 10, mk(0,0,2,1,0,1,0,0));
    add("edit_sel1",     1,0,0,0,0, 1, mk(0,0,2,1,1,1,0,0));
    add("edit_start",    0,0,1,0,0, 1, mk(0,0,2,1,0,0,1,0));
    add("run_inc_ign",   0,1,0,0,0, 1, mk(0,0,2,1,0,0,1,0));
    add("run_set_ign",   1,0,0,0,0, 1, mk(0,0,2,1,0,0,1,0));
    add("run_done",      0,0,0,1,0, 1, mk(0,0,2,1,0,0,0,1));
    add("alarm_4_pulse", 0,0,0,0,1, 4, mk(0,0,2,1,0,0,0,1));
    add("alarm_expire",  0,0,0,0,1, 1, mk(0,0,2,1,0,0,0,0));
    add("edit_again",    1,0,0,0,0, 1, mk(0,0,2,1,0,1,0,0));
    add("sec_to_5",      0,1,0,0,0, 5, mk(5,0,2,1,0,1,0,0));
    add("set_over_inc",  1,1,0,0,0, 1, mk(5,0,2,1,1,1,0,0));
    add("sel2_b",        1,0,0,0,0, 1, mk(5,0,2,1,2,1,0,0));
    add("min_wrap_x8",   0,1,0,0,0, 8, mk(5,0,0,1,2,1,0,0));
    add("sel3_b",        1,0,0,0,0, 1, mk(5,0,0,1,3,1,0,0));
    add("tmin_wrap_x9",  0,1,0,0,0, 9, mk(5,0,0,0,3,1,0,0));
    add("start_0005",    0,0,1,0,0, 1, mk(5,0,0,0,0,0,1,0));
    add("run_cancel",    0,0,1,0,0, 1, mk(5,0,0,0,0,0,0,0));
    add("restart",       0,0,1,0,0, 1, mk(5,0,0,0,0,0,1,0));
    add("done_over_st",  0,0,1,1,0, 1, mk(5,0,0,0,0,0,0,1));
    add("alarm_2_pulse", 0,0,0,0,1, 2, mk(5,0,0,0,0,0,0,1));
    add("alarm_btn_out", 0,1,0,0,0, 1, mk(5,0,0,0,0,0,0,0));
    add("run_again",     0,0,1,0,0, 1, mk(5,0,0,0,0,0,1,0));
    add("done_again",    0,0,0,1,0, 1, mk(5,0,0,0,0,0,0,1));
    add("alarm_5_pulse", 0,0,0,0,1, 5, mk(5,0,0,0,0,0,0,0));

    repeat (3) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].reps; r++)
        press(vecs[k].set, vecs[k].inc, vecs[k].start, vecs[k].done, vecs[k].pulse);
      chk(vecs[k].name, vecs[k].exp);
    end

    // Asynchronous reset in RUN clears everything before the next edge.
    press(0, 0, 1, 0, 0);
    chk("pre_reset_run", mk(5,0,0,0,0,0,1,0));
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("async_reset_run", mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Start with zero time keeps EDIT.
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    chk("edit_start_zero", mk(0,0,0,0,0,1,0,0));

    // Same-cycle set+start from IDLE runs.
    press(0, 1, 0, 0, 0);
    for (int n = 0; n < 4; n++) press(1, 0, 0, 0, 0);
    chk("idle_sec1", mk(1,0,0,0,0,0,0,0));
    press(1, 0, 1, 0, 0);
    chk("set_start_run", mk(1,0,0,0,0,0,1,0));
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);

    // Held inc gives exactly one increment.
    drive(0, 1, 0, 0, 0);
    repeat (20) @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("inc_held_20", mk(2,0,0,0,0,1,0,0));

    // Button held through reset release gives one event after release.
    drive(1, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_held_set", mk(0,0,0,0,0,0,0,0));
    reset = 1'b0;
    @(negedge clk);
    chk("event_after_rel", mk(0,0,0,0,0,1,0,0));
    repeat (3) @(negedge clk);
    chk("held_no_repeat", mk(0,0,0,0,0,1,0,0));
    drive(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
